mips_ctrl_pipe: RTL and testbench

Pipelined successor to the combinational MIPS main-control decoder. It decodes the ID-stage opcode into EX/M/WB control bundles and carries them through the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards, inserting one bubble per hazard cycle with a PC/IF-ID hold. It flushes wrong-path control on taken branches (resolved in MEM) and on jumps (decoded in ID). It sits beside the datapath pipeline registers; the datapath consumes its per-stage control outputs.

---
 rtl/mips_ctrl_pkg.sv | 39 +++
 rtl/mips_ctrl_decode.sv | 51 +++++
 rtl/mips_ctrl_pipe.sv | 98 +++++++++
 tb/tb_mips_ctrl_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, ALUOp codes and control-bundle layout for the pipelined
// MIPS main-control block.
package mips_ctrl_pkg;

  localparam int OP_W  = 6;
  localparam int M_W   = 4;
  localparam int WB_W  = 2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // EX bundle is {RegDst, ALUOp, ALUSrc}; RegDst index tracks the ALUOp width.
  localparam int EX_ALUSRC   = 0;
  localparam int M_BRANCH    = 3;
  localparam int M_MEMREAD   = 2;
  localparam int M_MEMWRITE  = 1;
  localparam int M_JUMP      = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  function automatic int ex_regdst(input int aluop_w);
    return aluop_w + 1;
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational main-control decode: opcode to EX/M/WB bundles, plus the
// illegal-opcode flag and whether the instruction reads rt as a source.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  logic                 valid,
  input  logic [OP_W-1:0]      op,
  output logic [ALUOP_W+1:0]   ex,
  output logic [M_W-1:0]       m,
  output logic [WB_W-1:0]      wb,
  output logic                 illegal,
  output logic                 uses_rt
);

  logic       regdst;
  logic [2:0] aluop;
  logic       alusrc;

  // Decode table; an invalid slot or unknown opcode yields an all-zero bubble.
  always_comb begin
    regdst  = 1'b0;
    aluop   = ALU_ADD;
    alusrc  = 1'b0;
    m       = 4'b0000;
    wb      = 2'b00;
    illegal = 1'b0;
    uses_rt = 1'b0;
    if (valid) begin
      case (op)
        OP_RTYPE: begin regdst = 1'b1; aluop = ALU_RTYPE; wb = 2'b10; uses_rt = 1'b1; end
        OP_LW:    begin alusrc = 1'b1; m = 4'b0100; wb = 2'b11; end
        OP_SW:    begin alusrc = 1'b1; m = 4'b0010; uses_rt = 1'b1; end
        OP_BEQ:   begin aluop = ALU_SUB; m = 4'b1000; uses_rt = 1'b1; end
        OP_ADDI:  begin alusrc = 1'b1; wb = 2'b10; end
        OP_SLTI:  begin aluop = ALU_SLT; alusrc = 1'b1; wb = 2'b10; end
        OP_ANDI:  begin aluop = ALU_AND; alusrc = 1'b1; wb = 2'b10; end
        OP_ORI:   begin aluop = ALU_OR; alusrc = 1'b1; wb = 2'b10; end
        OP_J:     begin m = 4'b0001; end
        default:  begin illegal = 1'b1; end
      endcase
    end else begin
      regdst  = 1'b0;
      alusrc  = 1'b0;
    end
  end

  assign ex = {regdst, ALUOP_W'(aluop), alusrc};

endmodule

// File: rtl/mips_ctrl_pipe.sv
// Pipelined MIPS control: ID decode, ID/EX, EX/MEM and MEM/WB control
// registers, load-use stall and branch/jump flush generation.
module mips_ctrl_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int ALUOP_W   = 3,
  parameter int HAZARD_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [OP_W-1:0]    id_op,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic               mem_zero,
  output logic [ALUOP_W+1:0] idex_ex,
  output logic [M_W-1:0]     idex_m,
  output logic [WB_W-1:0]    idex_wb,
  output logic [REG_AW-1:0]  idex_rt,
  output logic [M_W-1:0]     exmem_m,
  output logic [WB_W-1:0]    exmem_wb,
  output logic [WB_W-1:0]    memwb_wb,
  output logic               stall,
  output logic               if_flush,
  output logic               pc_src_branch,
  output logic               illegal_op
);

  localparam logic HZ_ON = (HAZARD_EN != 0);

  logic [ALUOP_W+1:0] dec_ex;
  logic [M_W-1:0]     dec_m;
  logic [WB_W-1:0]    dec_wb;
  logic               dec_illegal;
  logic               dec_uses_rt;
  logic               hz;

  mips_ctrl_decode #(.ALUOP_W(ALUOP_W)) u_decode (
    .valid   (id_valid),
    .op      (id_op),
    .ex      (dec_ex),
    .m       (dec_m),
    .wb      (dec_wb),
    .illegal (dec_illegal),
    .uses_rt (dec_uses_rt)
  );

  assign hz = HZ_ON & id_valid & idex_m[M_MEMREAD] & (idex_rt != '0) &
              ((idex_rt == id_rs) | ((idex_rt == id_rt) & dec_uses_rt));

  // A taken branch squashes the ID instruction, so it overrides the stall.
  assign pc_src_branch = exmem_m[M_BRANCH] & mem_zero;
  assign stall         = hz & ~pc_src_branch;
  assign if_flush      = pc_src_branch | (id_valid & dec_m[M_JUMP] & ~stall);

  // Control pipeline registers: reset > branch flush > stall > normal advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_ex    <= '0;
      idex_m     <= '0;
      idex_wb    <= '0;
      idex_rt    <= '0;
      exmem_m    <= '0;
      exmem_wb   <= '0;
      memwb_wb   <= '0;
      illegal_op <= 1'b0;
    end else if (pc_src_branch) begin
      idex_ex    <= '0;
      idex_m     <= '0;
      idex_wb    <= '0;
      idex_rt    <= '0;
      exmem_m    <= '0;
      exmem_wb   <= '0;
      memwb_wb   <= exmem_wb;
      illegal_op <= 1'b0;
    end else if (stall) begin
      idex_ex    <= '0;
      idex_m     <= '0;
      idex_wb    <= '0;
      idex_rt    <= '0;
      exmem_m    <= idex_m;
      exmem_wb   <= idex_wb;
      memwb_wb   <= exmem_wb;
      illegal_op <= 1'b0;
    end else begin
      idex_ex    <= dec_ex;
      idex_m     <= dec_m;
      idex_wb    <= dec_wb;
      idex_rt    <= id_rt;
      exmem_m    <= idex_m;
      exmem_wb   <= idex_wb;
      memwb_wb   <= exmem_wb;
      illegal_op <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// Directed self-checking bench for mips_ctrl_pipe with hand-computed bundles;
// a second instance with HAZARD_EN=0 shares the inputs.
module tb_mips_ctrl_pipe;
  import mips_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_op;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       mem_zero;

  logic [4:0] idex_ex,  n_idex_ex;
  logic [3:0] idex_m,   n_idex_m;
  logic [1:0] idex_wb,  n_idex_wb;
  logic [4:0] idex_rt,  n_idex_rt;
  logic [3:0] exmem_m,  n_exmem_m;
  logic [1:0] exmem_wb, n_exmem_wb;
  logic [1:0] memwb_wb, n_memwb_wb;
  logic       stall, n_stall;
  logic       if_flush, n_if_flush;
  logic       pc_src_branch, n_pc_src_branch;
  logic       illegal_op, n_illegal_op;

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected {EX, M, WB} bundles, 5+4+2 bits.
  localparam logic [10:0] B_LW   = 11'b00001_0100_11;
  localparam logic [10:0] B_R    = 11'b10100_0000_10;
  localparam logic [10:0] B_SW   = 11'b00001_0010_00;
  localparam logic [10:0] B_BEQ  = 11'b00010_1000_00;
  localparam logic [10:0] B_ADDI = 11'b00001_0000_10;
  localparam logic [10:0] B_SLTI = 11'b01011_0000_10;
  localparam logic [10:0] B_ANDI = 11'b01001_0000_10;
  localparam logic [10:0] B_ORI  = 11'b00111_0000_10;
  localparam logic [10:0] B_J    = 11'b00000_0001_00;

  mips_ctrl_pipe #(.REG_AW(5), .ALUOP_W(3), .HAZARD_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .mem_zero(mem_zero),
    .idex_ex(idex_ex), .idex_m(idex_m), .idex_wb(idex_wb), .idex_rt(idex_rt),
    .exmem_m(exmem_m), .exmem_wb(exmem_wb), .memwb_wb(memwb_wb),
    .stall(stall), .if_flush(if_flush), .pc_src_branch(pc_src_branch),
    .illegal_op(illegal_op)
  );

  mips_ctrl_pipe #(.REG_AW(5), .ALUOP_W(3), .HAZARD_EN(0)) u_nohz (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .mem_zero(mem_zero),
    .idex_ex(n_idex_ex), .idex_m(n_idex_m), .idex_wb(n_idex_wb), .idex_rt(n_idex_rt),
    .exmem_m(n_exmem_m), .exmem_wb(n_exmem_wb), .memwb_wb(n_memwb_wb),
    .stall(n_stall), .if_flush(n_if_flush), .pc_src_branch(n_pc_src_branch),
    .illegal_op(n_illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idex(input string tag, input logic [10:0] exp);
    chk(tag, {21'd0, idex_ex, idex_m, idex_wb}, {21'd0, exp});
  endtask

  task automatic chk_exmem(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, exmem_m, exmem_wb}, {26'd0, exp});
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    id_valid = v;
    id_op    = op;
    id_rs    = rs;
    id_rt    = rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  s_op  [10];
  logic        s_v   [10];
  logic [10:0] s_exp [10];
  logic [10:0] prev1, prev2;

  initial begin
    rst_n = 1'b0;
    mem_zero = 1'b0;
    drive(1'b1, OP_LW, 5'd1, 5'd7);

    // Reset holds everything at zero even with a lw in ID.
    tick();
    tick();
    chk_idex("rst_idex", 11'd0);
    chk("rst_idex_rt", {27'd0, idex_rt}, 32'd0);
    chk_exmem("rst_exmem", 6'd0);
    chk("rst_memwb", {30'd0, memwb_wb}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, if_flush}, 32'd0);
    chk("rst_pcsrc", {31'd0, pc_src_branch}, 32'd0);
    rst_n = 1'b1;

    // Instruction stream through the three control stages.
    s_op[0] = OP_LW;   s_v[0] = 1'b1; s_exp[0] = B_LW;
    s_op[1] = OP_RTYPE; s_v[1] = 1'b1; s_exp[1] = B_R;
    s_op[2] = OP_SW;   s_v[2] = 1'b1; s_exp[2] = B_SW;
    s_op[3] = OP_ADDI; s_v[3] = 1'b1; s_exp[3] = B_ADDI;
    s_op[4] = OP_SLTI; s_v[4] = 1'b1; s_exp[4] = B_SLTI;
    s_op[5] = OP_ORI;  s_v[5] = 1'b1; s_exp[5] = B_ORI;
    s_op[6] = OP_ANDI; s_v[6] = 1'b1; s_exp[6] = B_ANDI;
    for (int i = 7; i < 10; i++) begin
      s_op[i] = OP_RTYPE; s_v[i] = 1'b0; s_exp[i] = 11'd0;
    end
    prev1 = 11'd0;
    prev2 = 11'd0;
    for (int i = 0; i < 10; i++) begin
      drive(s_v[i], s_op[i], 5'd1, (i == 0) ? 5'd7 : 5'd2);
      tick();
      chk_idex("stream_idex", s_exp[i]);
      chk_exmem("stream_exmem", prev1[5:0]);
      chk("stream_memwb", {30'd0, memwb_wb}, {30'd0, prev2[1:0]});
      chk("stream_stall", {31'd0, stall}, 32'd0);
      prev2 = prev1;
      prev1 = s_exp[i];
    end

    // Load-use: lw rt=5 then add rs=5 gives one bubble.
    drive(1'b1, OP_LW, 5'd1, 5'd5);
    tick();
    chk("lu_idex_rt", {27'd0, idex_rt}, 32'd5);
    drive(1'b1, OP_RTYPE, 5'd5, 5'd2);
    #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_nohz_stall", {31'd0, n_stall}, 32'd0);
    chk("lu_flush", {31'd0, if_flush}, 32'd0);
    tick();
    chk_idex("lu_bubble", 11'd0);
    chk_exmem("lu_exmem_lw", B_LW[5:0]);
    chk("lu_stall_clear", {31'd0, stall}, 32'd0);
    tick();
    chk_idex("lu_add_idex", B_R);
    drive(1'b1, OP_RTYPE, 5'd5, 5'd5);
    #1;
    chk("lu_second_dep", {31'd0, stall}, 32'd0);
    drive(1'b1, OP_LW, 5'd1, 5'd0);
    tick();
    drive(1'b1, OP_RTYPE, 5'd0, 5'd0);
    #1;
    chk("lu_rt0", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b1, OP_LW, 5'd1, 5'd6);
    tick();
    drive(1'b1, OP_ADDI, 5'd1, 5'd6);
    #1;
    chk("lu_addi_rt", {31'd0, stall}, 32'd0);
    drive(1'b1, OP_SW, 5'd1, 5'd6);
    #1;
    chk("lu_sw_rt", {31'd0, stall}, 32'd1);
    drive(1'b0, OP_SW, 5'd1, 5'd6);
    #1;
    chk("lu_invalid", {31'd0, stall}, 32'd0);
    tick();
    tick();
    tick();

    // Taken branch in EX/MEM squashes ID/EX and EX/MEM.
    mem_zero = 1'b1;
    drive(1'b1, OP_BEQ, 5'd1, 5'd2);
    tick();
    chk_idex("beq_idex", B_BEQ);
    drive(1'b1, OP_ORI, 5'd1, 5'd2);
    tick();
    drive(1'b1, OP_ADDI, 5'd1, 5'd2);
    #1;
    chk("br_pcsrc", {31'd0, pc_src_branch}, 32'd1);
    chk("br_flush", {31'd0, if_flush}, 32'd1);
    chk("br_stall", {31'd0, stall}, 32'd0);
    tick();
    chk_idex("br_idex_zero", 11'd0);
    chk_exmem("br_exmem_zero", 6'd0);
    chk("br_memwb", {30'd0, memwb_wb}, 32'd0);
    drive(1'b0, OP_RTYPE, 5'd0, 5'd0);
    tick();
    tick();

    // Untaken branch: no flush.
    mem_zero = 1'b0;
    drive(1'b1, OP_BEQ, 5'd1, 5'd2);
    tick();
    drive(1'b1, OP_ORI, 5'd1, 5'd2);
    tick();
    drive(1'b1, OP_ADDI, 5'd1, 5'd2);
    #1;
    chk("nbr_pcsrc", {31'd0, pc_src_branch}, 32'd0);
    chk("nbr_flush", {31'd0, if_flush}, 32'd0);
    tick();
    chk_idex("nbr_idex", B_ADDI);
    chk_exmem("nbr_exmem", B_ORI[5:0]);
    chk("nbr_memwb", {30'd0, memwb_wb}, 32'd0);
    drive(1'b0, OP_RTYPE, 5'd0, 5'd0);
    tick();
    tick();
    tick();

    // Jump flushes IF/ID; under a stall the flush waits.
    drive(1'b1, OP_J, 5'd1, 5'd2);
    #1;
    chk("j_flush", {31'd0, if_flush}, 32'd1);
    tick();
    chk_idex("j_idex", B_J);
    drive(1'b0, OP_RTYPE, 5'd0, 5'd0);
    #1;
    chk("j_flush_end", {31'd0, if_flush}, 32'd0);
    drive(1'b1, OP_LW, 5'd1, 5'd5);
    tick();
    drive(1'b1, OP_J, 5'd5, 5'd0);
    #1;
    chk("jst_stall", {31'd0, stall}, 32'd1);
    chk("jst_flush_held", {31'd0, if_flush}, 32'd0);
    tick();
    chk("jst_stall_clear", {31'd0, stall}, 32'd0);
    chk("jst_flush_now", {31'd0, if_flush}, 32'd1);
    tick();
    chk_idex("jst_idex", B_J);

    // Unknown opcode.
    drive(1'b1, 6'b111111, 5'd1, 5'd2);
    tick();
    chk("ill_pulse", {31'd0, illegal_op}, 32'd1);
    chk_idex("ill_idex", 11'd0);
    drive(1'b0, OP_RTYPE, 5'd0, 5'd0);
    tick();
    chk("ill_clear", {31'd0, illegal_op}, 32'd0);

    // Hazard and taken branch together: flush wins.
    mem_zero = 1'b1;
    drive(1'b1, OP_BEQ, 5'd1, 5'd2);
    tick();
    drive(1'b1, OP_LW, 5'd1, 5'd5);
    tick();
    drive(1'b1, OP_RTYPE, 5'd5, 5'd2);
    #1;
    chk("hf_stall", {31'd0, stall}, 32'd0);
    chk("hf_pcsrc", {31'd0, pc_src_branch}, 32'd1);
    chk("hf_flush", {31'd0, if_flush}, 32'd1);
    tick();
    chk_idex("hf_idex_zero", 11'd0);
    chk_exmem("hf_exmem_zero", 6'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
